// File: rtl/axis_video_pattern_src_pkg.sv
// Shared types and constants for the AXI4-Stream video test-pattern source.
package axis_video_pattern_src_pkg;

  typedef enum logic [1:0] {
    PatSolid = 2'd0,
    PatBars  = 2'd1,
    PatCheck = 2'd2,
    PatGrad  = 2'd3
  } pat_mode_e;

  typedef enum logic {
    StIdle   = 1'b0,
    StStream = 1'b1
  } state_e;

  // Per-bar {R,G,B} on/off; entry 0 is the leftmost bar (white) through 7 (black).
  localparam logic [7:0][2:0] BarTable = {
    3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
  };

endpackage

// File: rtl/axis_video_pattern_src_if.sv
// AXI4-Stream video bus: pixel data plus start-of-frame (tuser) and end-of-line (tlast).
interface axis_video_pattern_src_if #(
  parameter int unsigned DATA_W = 24
) ();
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tuser;
  logic              tlast;
  logic              tready;

  modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/axis_video_pattern_src_pixel.sv
// Combinational pixel generator: maps (x, y, mode, expanded fill) to one {R,G,B} pixel.
module axis_video_pattern_src_pixel
  import axis_video_pattern_src_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned COMP_W     = 8,
  parameter int unsigned CHECK_LOG2 = 5,
  parameter int unsigned XW         = 10,
  parameter int unsigned YW         = 9
) (
  input  logic [XW-1:0]       x_i,
  input  logic [YW-1:0]       y_i,
  input  pat_mode_e           mode_i,
  input  logic [3*COMP_W-1:0] fill_i,
  output logic [3*COMP_W-1:0] pixel_o
);
  localparam int unsigned BarW = H_ACTIVE / 8;
  localparam int unsigned SumW = ((XW > YW) ? XW : YW) + 1;

  logic [31:0]     x_ext, y_ext, bar_idx;
  logic [2:0]      bar_sel, bar_rgb;
  logic            chk_on;
  logic [SumW-1:0] sum;

  always_comb begin
    x_ext   = 32'(x_i);
    y_ext   = 32'(y_i);
    bar_idx = x_ext / BarW;
    // Saturate so a width not divisible by 8 folds its remainder into the last bar.
    bar_sel = (bar_idx > 32'd7) ? 3'd7 : bar_idx[2:0];
    bar_rgb = BarTable[bar_sel];
    chk_on  = |(((x_ext ^ y_ext) >> CHECK_LOG2) & 32'd1);
    sum     = SumW'(x_i) + SumW'(y_i);

    pixel_o = '0;
    unique case (mode_i)
      PatSolid: pixel_o = fill_i;
      PatBars:  pixel_o = {{COMP_W{bar_rgb[2]}}, {COMP_W{bar_rgb[1]}}, {COMP_W{bar_rgb[0]}}};
      PatCheck: pixel_o = chk_on ? fill_i : '0;
      PatGrad:  pixel_o = {COMP_W'(x_i), COMP_W'(y_i), COMP_W'(sum)};
      default:  pixel_o = '0;
    endcase
  end

endmodule

// File: rtl/axis_video_pattern_src.sv
// AXI4-Stream video master producing whole frames of test pattern, started and stopped
// only at frame boundaries, with a wrapping completed-frame counter.
module axis_video_pattern_src
  import axis_video_pattern_src_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned COMP_W     = 8,
  parameter int unsigned FILL_W     = 4,
  parameter int unsigned CHECK_LOG2 = 5,
  parameter int unsigned FCNT_W     = 16
) (
  input  logic                  pixel_clk,
  input  logic                  aresetn,
  input  logic                  enable,
  input  logic [1:0]            mode,
  input  logic [3*FILL_W-1:0]   fill_color,
  output logic                  busy,
  output logic [FCNT_W-1:0]     frame_count,
  axis_video_pattern_src_if.master axis
);
  localparam int unsigned XW    = $clog2(H_ACTIVE);
  localparam int unsigned YW    = $clog2(V_ACTIVE);
  localparam int unsigned DataW = 3 * COMP_W;

  state_e            state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  pat_mode_e         mode_q, mode_d;
  logic [DataW-1:0]  fill_q, fill_d, fill_exp, pixel, tdata_q, tdata_d;
  logic              tvalid_q, tvalid_d, tuser_q, tuser_d, tlast_q, tlast_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              load, last_x, last_y;

  // Replicate each fill component MSB-first up to COMP_W bits.
  always_comb begin
    fill_exp = '0;
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < int'(COMP_W); i++) begin
        fill_exp[c*COMP_W + COMP_W - 1 - i] = fill_color[c*FILL_W + FILL_W - 1 - (i % FILL_W)];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    mode_d   = mode_q;
    fill_d   = fill_q;
    tvalid_d = tvalid_q;
    tuser_d  = tuser_q;
    tlast_d  = tlast_q;
    fcnt_d   = fcnt_q;
    load     = 1'b0;
    last_x   = (x_q == XW'(H_ACTIVE - 1));
    last_y   = (y_q == YW'(V_ACTIVE - 1));

    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d  = StStream;
          x_d      = '0;
          y_d      = '0;
          mode_d   = pat_mode_e'(mode);
          fill_d   = fill_exp;
          tvalid_d = 1'b1;
          tuser_d  = 1'b1;
          tlast_d  = 1'b0;
          load     = 1'b1;
        end
      end
      StStream: begin
        if (tvalid_q && axis.tready) begin
          if (last_x && last_y) begin
            fcnt_d = fcnt_q + FCNT_W'(1);
            if (enable) begin
              x_d     = '0;
              y_d     = '0;
              mode_d  = pat_mode_e'(mode);
              fill_d  = fill_exp;
              tuser_d = 1'b1;
              tlast_d = 1'b0;
              load    = 1'b1;
            end else begin
              state_d  = StIdle;
              tvalid_d = 1'b0;
              tuser_d  = 1'b0;
              tlast_d  = 1'b0;
            end
          end else begin
            x_d     = last_x ? '0 : x_q + XW'(1);
            y_d     = last_x ? y_q + YW'(1) : y_q;
            tuser_d = 1'b0;
            tlast_d = (x_q == XW'(H_ACTIVE - 2));
            load    = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  axis_video_pattern_src_pixel #(
    .H_ACTIVE  (H_ACTIVE),
    .COMP_W    (COMP_W),
    .CHECK_LOG2(CHECK_LOG2),
    .XW        (XW),
    .YW        (YW)
  ) u_pixel (
    .x_i    (x_d),
    .y_i    (y_d),
    .mode_i (mode_d),
    .fill_i (fill_d),
    .pixel_o(pixel)
  );

  assign tdata_d = load ? pixel : tdata_q;

  always_ff @(posedge pixel_clk) begin
    if (!aresetn) begin
      state_q  <= StIdle;
      x_q      <= '0;
      y_q      <= '0;
      mode_q   <= PatSolid;
      fill_q   <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tuser_q  <= 1'b0;
      tlast_q  <= 1'b0;
      fcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      mode_q   <= mode_d;
      fill_q   <= fill_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tuser_q  <= tuser_d;
      tlast_q  <= tlast_d;
      fcnt_q   <= fcnt_d;
    end
  end

  assign axis.tdata  = tdata_q;
  assign axis.tvalid = tvalid_q;
  assign axis.tuser  = tuser_q;
  assign axis.tlast  = tlast_q;
  assign busy        = (state_q == StStream);
  assign frame_count = fcnt_q;

endmodule

// File: tb/tb_axis_video_pattern_src.sv
// Directed bench for axis_video_pattern_src at 16x4; a second instance with a 2-bit
// frame counter shares the stimulus to exercise counter wrap.
module tb_axis_video_pattern_src;

  logic        pixel_clk = 1'b0;
  logic        aresetn   = 1'b0;
  logic        enable    = 1'b0;
  logic [1:0]  mode      = 2'd0;
  logic [11:0] fill_color = 12'h000;
  logic        tready    = 1'b0;
  logic        busy, busy2;
  logic [15:0] frame_count;
  logic [1:0]  frame_count2;

  int checks   = 0;
  int failures = 0;
  int fc_exp   = 0;
  logic [23:0] pix [256];

  axis_video_pattern_src_if #(.DATA_W(24)) axis ();
  axis_video_pattern_src_if #(.DATA_W(24)) axis2 ();
  assign axis.tready  = tready;
  assign axis2.tready = tready;

  axis_video_pattern_src #(
    .H_ACTIVE(16), .V_ACTIVE(4), .COMP_W(8), .FILL_W(4), .CHECK_LOG2(2), .FCNT_W(16)
  ) dut (
    .pixel_clk  (pixel_clk),
    .aresetn    (aresetn),
    .enable     (enable),
    .mode       (mode),
    .fill_color (fill_color),
    .busy       (busy),
    .frame_count(frame_count),
    .axis       (axis)
  );

  axis_video_pattern_src #(
    .H_ACTIVE(16), .V_ACTIVE(4), .COMP_W(8), .FILL_W(4), .CHECK_LOG2(2), .FCNT_W(2)
  ) dut2 (
    .pixel_clk  (pixel_clk),
    .aresetn    (aresetn),
    .enable     (enable),
    .mode       (mode),
    .fill_color (fill_color),
    .busy       (busy2),
    .frame_count(frame_count2),
    .axis       (axis2)
  );

  always #5 pixel_clk = ~pixel_clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [23:0] exp_pix(input int m, input logic [11:0] f, input int x,
                                          input int y);
    logic [7:0] r, g, b;
    logic [23:0] fe;
    r  = {f[11:8], f[11:8]};
    g  = {f[7:4], f[7:4]};
    b  = {f[3:0], f[3:0]};
    fe = {r, g, b};
    case (m)
      0: return fe;
      1: case (x / 2)
           0: return 24'hFFFFFF;
           1: return 24'hFFFF00;
           2: return 24'h00FFFF;
           3: return 24'h00FF00;
           4: return 24'hFF00FF;
           5: return 24'hFF0000;
           6: return 24'h0000FF;
           default: return 24'h000000;
         endcase
      2: return ((((x >> 2) ^ (y >> 2)) & 1) != 0) ? fe : 24'h0;
      default: return {8'(x), 8'(y), 8'(x + y)};
    endcase
  endfunction

  // Drives tready and consumes nbeats transfers starting at the current negedge.
  task automatic stream(input int nbeats, input bit rnd, input int drop_at, input int chg_at,
                        input int m_a, input int m_b, input logic [11:0] f);
    int k = 0;
    bit stalled = 0;
    logic [23:0] s_data = '0;
    logic s_user = 1'b0, s_last = 1'b0;
    int x, y;
    for (int cyc = 0; cyc < nbeats * 4 + 40 && k < nbeats; cyc++) begin
      tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (k == drop_at) enable = 1'b0;
      if (k == chg_at) mode = 2'd2;
      if (stalled) begin
        check_eq("hold_tdata", 32'(axis.tdata), 32'(s_data));
        check_eq("hold_tuser", 32'(axis.tuser), 32'(s_user));
        check_eq("hold_tlast", 32'(axis.tlast), 32'(s_last));
      end
      check_eq("tvalid_held", 32'(axis.tvalid), 32'd1);
      stalled = 1'b0;
      if (axis.tvalid && tready) begin
        x = k % 16;
        y = (k / 16) % 4;
        check_eq("tdata", 32'(axis.tdata), 32'(exp_pix((k < 64) ? m_a : m_b, f, x, y)));
        check_eq("tuser", 32'(axis.tuser), 32'(k % 64 == 0));
        check_eq("tlast", 32'(axis.tlast), 32'(x == 15));
        check_eq("frame_count", 32'(frame_count), 32'(fc_exp));
        check_eq("frame_count_w2", 32'(frame_count2), 32'(fc_exp % 4));
        pix[k] = axis.tdata;
        if (k % 64 == 63) fc_exp++;
        k++;
      end else if (axis.tvalid) begin
        stalled = 1'b1;
        s_data  = axis.tdata;
        s_user  = axis.tuser;
        s_last  = axis.tlast;
      end
      @(negedge pixel_clk);
    end
    check_eq("beats", 32'(k), 32'(nbeats));
    tready = 1'b0;
  endtask

  task automatic start(input logic [1:0] m, input logic [11:0] f);
    mode       = m;
    fill_color = f;
    enable     = 1'b1;
    check_eq("tvalid_before_start", 32'(axis.tvalid), 32'd0);
    @(negedge pixel_clk);
    check_eq("tvalid_rise", 32'(axis.tvalid), 32'd1);
    check_eq("tuser_first", 32'(axis.tuser), 32'd1);
    check_eq("busy_stream", 32'(busy), 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge pixel_clk);
    check_eq("rst_tvalid", 32'(axis.tvalid), 32'd0);
    check_eq("rst_tuser", 32'(axis.tuser), 32'd0);
    check_eq("rst_tlast", 32'(axis.tlast), 32'd0);
    check_eq("rst_tdata", 32'(axis.tdata), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_fcnt", 32'(frame_count), 32'd0);
    aresetn = 1'b1;
    @(negedge pixel_clk);
    check_eq("idle_busy", 32'(busy), 32'd0);

    // Solid fill, full-rate ready, single frame.
    start(2'd0, 12'hA5F);
    check_eq("solid_first", 32'(axis.tdata), 32'hAA55FF);
    stream(64, 1'b0, 10, -1, 0, 0, 12'hA5F);
    check_eq("t1_tvalid_end", 32'(axis.tvalid), 32'd0);
    check_eq("t1_busy_end", 32'(busy), 32'd0);
    check_eq("t1_fcnt", 32'(frame_count), 32'd1);

    // Gradient, random backpressure, two frames with enable dropped in frame 2.
    @(negedge pixel_clk);
    start(2'd3, 12'h000);
    stream(128, 1'b1, 74, -1, 3, 3, 12'h000);
    check_eq("grad_5_3", 32'(pix[64 + 3 * 16 + 5]), 32'h050308);
    check_eq("grad_15_3", 32'(pix[64 + 63]), 32'h0F0312);
    check_eq("t2_tvalid_end", 32'(axis.tvalid), 32'd0);
    check_eq("t2_busy_end", 32'(busy), 32'd0);
    check_eq("t2_fcnt", 32'(frame_count), 32'd3);

    // Bars, mode switched to checker mid-frame; takes effect at the next frame.
    @(negedge pixel_clk);
    start(2'd1, 12'hF00);
    stream(128, 1'b0, 70, 20, 1, 2, 12'hF00);
    check_eq("bar_x0", 32'(pix[0]), 32'hFFFFFF);
    check_eq("bar_x1", 32'(pix[1]), 32'hFFFFFF);
    check_eq("bar_x2", 32'(pix[2]), 32'hFFFF00);
    check_eq("bar_x3", 32'(pix[3]), 32'hFFFF00);
    check_eq("bar_x14", 32'(pix[14]), 32'h000000);
    check_eq("bar_x15", 32'(pix[15]), 32'h000000);
    check_eq("bar_after_chg", 32'(pix[16 + 4]), 32'h00FFFF);
    check_eq("chk_0_0", 32'(pix[64]), 32'h000000);
    check_eq("chk_4_0", 32'(pix[64 + 4]), 32'hFF0000);
    check_eq("chk_4_1", 32'(pix[64 + 16 + 4]), 32'hFF0000);
    check_eq("t3_fcnt", 32'(frame_count), 32'd5);
    check_eq("t3_fcnt_w2", 32'(frame_count2), 32'd1);

    // Reset in the middle of a frame, then restart from (0,0).
    mode = 2'd0;
    @(negedge pixel_clk);
    start(2'd0, 12'h123);
    stream(20, 1'b0, -1, -1, 0, 0, 12'h123);
    check_eq("pre_rst_tvalid", 32'(axis.tvalid), 32'd1);
    aresetn = 1'b0;
    @(negedge pixel_clk);
    check_eq("mid_rst_tvalid", 32'(axis.tvalid), 32'd0);
    check_eq("mid_rst_tuser", 32'(axis.tuser), 32'd0);
    check_eq("mid_rst_tlast", 32'(axis.tlast), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_fcnt", 32'(frame_count), 32'd0);
    check_eq("mid_rst_fcnt_w2", 32'(frame_count2), 32'd0);
    fc_exp  = 0;
    aresetn = 1'b1;
    @(negedge pixel_clk);
    check_eq("restart_tvalid", 32'(axis.tvalid), 32'd1);
    check_eq("restart_tuser", 32'(axis.tuser), 32'd1);
    check_eq("restart_tdata", 32'(axis.tdata), 32'h112233);
    stream(64, 1'b0, 5, -1, 0, 0, 12'h123);
    check_eq("t4_fcnt", 32'(frame_count), 32'd1);
    check_eq("t4_tvalid_end", 32'(axis.tvalid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_video_pattern_src.md
Name: axis_video_pattern_src

Overview:
- Parametrised AXI4-Stream video master that generates full frames of test-pattern or solid-fill pixels for the HDMI block design's video input.
- Supersedes the fixed 640x480, RGB444, no-backpressure pixel source.
- Adds configurable resolution, component width, selectable pattern modes and tready backpressure.
- Adds frame-boundary start/stop control and a frame counter.
- Sits between the game logic (fill colour, mode select) and the AXI4-Stream-to-video-out bridge, in the pixel_clk domain.

Parameters:
- H_ACTIVE, 640, active pixels per line (>=8).
- V_ACTIVE, 480, active lines per frame (>=2).
- COMP_W, 8, output bits per colour component; tdata width is 3*COMP_W.
- FILL_W, 4, bits per component of the fill_color input (1..COMP_W).
- CHECK_LOG2, 5, checker square size is 2**CHECK_LOG2 pixels.
- FCNT_W, 16, frame counter width.

Ports:
- pixel_clk  in  1  sole clock.
- aresetn  in  1  synchronous active-low reset.
- enable  in  1  request streaming; sampled only at frame boundaries.
- mode  in  2  pattern: 0 solid, 1 colour bars, 2 checker, 3 gradient; sampled at frame start.
- fill_color  in  3*FILL_W  {R,G,B} used by mode 0 and as the checker "on" colour; sampled at frame start.
- tdata  out  3*COMP_W  pixel {R,G,B}.
- tvalid  out  1  AXI4-Stream valid.
- tuser  out  1  start of frame; high on pixel (0,0) only.
- tlast  out  1  end of line; high on x==H_ACTIVE-1.
- tready  in  1  AXI4-Stream ready from the bridge.
- busy  out  1  high in STREAM state.
- frame_count  out  FCNT_W  completed frames; wraps modulo 2**FCNT_W.

Behaviour:
- Reset (aresetn low at a clock edge):
  - tvalid, tuser, tlast, busy = 0; tdata = 0; frame_count = 0.
  - x = y = 0; state = IDLE.
  - Reset takes priority over everything, including mid-frame; the partial frame is abandoned and no tlast or tuser is forced.
- States are IDLE and STREAM.
  - IDLE -> STREAM on a cycle with enable=1. That same edge latches mode and fill_color into frame registers, loads pixel (0,0) and sets tvalid=1, tuser=1. First valid is therefore 1 cycle after enable is sampled high.
  - STREAM: a transfer occurs on any cycle with tvalid && tready. While tvalid && !tready, tdata, tuser and tlast hold stable (AXI rule); tvalid never drops until the transfer completes.
  - Per transfer, x increments. At x==H_ACTIVE-1, x wraps to 0 and y increments. The next pixel is registered on the same edge, so there are no bubbles under continuous tready.
  - End of frame is the transfer of (H_ACTIVE-1, V_ACTIVE-1). On that edge frame_count increments.
    - If enable=1: re-latch mode and fill_color, load (0,0) with tuser=1 and stay in STREAM (back-to-back frames, no gap).
    - If enable=0: tvalid=0, go to IDLE.
  - enable falling mid-frame has no effect until end of frame. mode and fill_color changes mid-frame are ignored.
- Width rules:
  - Fill expansion is by bit replication: an FILL_W component is repeated and truncated to COMP_W MSB-first. Example: 4'hA -> 8'hAA; 4'hF -> 8'hFF.
  - Mode 0: every pixel = expanded fill_color.
  - Mode 1 (colour bars):
    - bar index b = x / (H_ACTIVE/8), saturated at 7.
    - Bar colour in order white, yellow, cyan, green, magenta, red, blue, black. Each component is all-ones or zero.
  - Mode 2 (checker): if x[CHECK_LOG2] XOR y[CHECK_LOG2], pixel = expanded fill_color; otherwise pixel = 0.
  - Mode 3 (gradient):
    - R = x, G = y, B = x+y.
    - Each is taken modulo 2**COMP_W (low COMP_W bits, zero-extended if narrower).
  - Counters are wide enough for H_ACTIVE-1 and V_ACTIVE-1 ($clog2). The gradient sum is computed one bit wider, then truncated.
- busy = (state==STREAM). It drops on the same edge tvalid drops.

Decomposition:
- starsoc_params holds:
  - pattern mode enum: PAT_SOLID, PAT_BARS, PAT_CHECK, PAT_GRAD.
  - state enum: IDLE, STREAM.
  - 8-entry colour-bar constant table (3-bit on/off per bar).
- One combinational sub-module, video_pattern_pixel:
  - Inputs: x, y, latched mode, expanded fill.
  - Output: next pixel.
  - The top handles the FSM, counters, handshake and registers.

Test Plan (H_ACTIVE=16, V_ACTIVE=4, COMP_W=8, FILL_W=4, CHECK_LOG2=2 unless stated):
- Reset, then enable=1 one cycle later, tready=1, mode=0, fill=12'hA5F -> tvalid rises 1 cycle after enable. 64 pixels all 24'hAA55FF. tuser only on the first; tlast on beats 16/32/48/64. frame_count=1 after the last beat.
- Random tready (~50%), mode=3 -> tdata, tuser and tlast hold stable while stalled. Pixel (5,3) = {8'h05, 8'h03, 8'h08}. Exactly 64 transfers per frame.
- enable high for 2 frames, dropped at beat 10 of frame 2 -> frame 2 completes (64 beats). tvalid=0 and busy=0 on the edge after beat 64. frame_count=2.
- Mode 1 -> x=0,1 white 24'hFFFFFF; x=2,3 yellow 24'hFFFF00; x=14,15 black. mode changed to 2 mid-frame -> bars persist until the next tuser.
- Mode 2, fill=12'hF00 -> pixel (4,0) = 24'hFF0000, (0,0) = 0, (4,4 if V_ACTIVE=8) = 0.
- aresetn low at beat 20 with tvalid=1 -> next cycle tvalid=0, frame_count=0. Re-enable restarts at (0,0) with tuser=1.
- FCNT_W=2, 4 frames -> frame_count 1, 2, 3, 0.
